// File: rtl/mc_ctrl_if.sv
// Control-unit <-> multi-cycle datapath bundle: IR fields and memory
// handshake in, datapath enables/selects and status out.
interface mc_ctrl_if;
  logic [5:0] instr_op_i;
  logic [5:0] funct_i;
  logic       mem_ready_i;
  logic       PC_write_o;
  logic       IR_write_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       RegWrite_o;
  logic [1:0] RegDst_o;
  logic [1:0] RegWriteSrc_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALU_op_o;
  logic [1:0] PC_src_o;
  logic       Branch_o;
  logic [1:0] Branch_type_o;
  logic       instr_done_o;
  logic [1:0] fault_o;
  logic [2:0] state_o;

  // control unit side
  modport master (
    input  instr_op_i, funct_i, mem_ready_i,
    output PC_write_o, IR_write_o, MemRead_o, MemWrite_o, RegWrite_o,
           RegDst_o, RegWriteSrc_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
           PC_src_o, Branch_o, Branch_type_o, instr_done_o, fault_o, state_o
  );

  // datapath side
  modport slave (
    output instr_op_i, funct_i, mem_ready_i,
    input  PC_write_o, IR_write_o, MemRead_o, MemWrite_o, RegWrite_o,
           RegDst_o, RegWriteSrc_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
           PC_src_o, Branch_o, Branch_type_o, instr_done_o, fault_o, state_o
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/wb sequencing with a
// memory wait-state timeout, illegal-opcode trap and per-instruction done pulse.
module mc_control_unit #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLE   = 6'h06;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Last waiting cycle index before the access is declared dead.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       fault_q, fault_d;
  logic [5:0]       op_q, funct_q;

  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, wsrc, src_b, pc_src, br_type;
  logic       src_a, branch, done;
  logic [2:0] alu_op;

  logic is_r, is_nop, is_sw, is_jr;

  assign is_r    = (op_q == OP_RTYPE);
  assign is_nop  = is_r && (funct_q == 6'h00);
  assign is_jr   = is_r && (funct_q == FN_JR);
  assign is_sw   = (op_q == OP_SW);
  // Saturating increment so a huge TIMEOUT never wraps back to zero.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // State, wait counter, sticky fault and IR field latch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      fault_q <= 2'b00;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      if (state_q == S_DECODE) begin
        op_q    <= bus.instr_op_i;
        funct_q <= bus.funct_i;
      end
    end
  end

  // Next state plus Moore outputs (IR/PC write and sw done follow mem_ready_i)
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;          // any non-waiting cycle clears it, covering entry to FETCH/MEM
    fault_d   = fault_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 2'b00;
    wsrc      = 2'b00;
    src_a     = 1'b0;
    src_b     = 2'b00;
    alu_op    = 3'b000;
    pc_src    = 2'b00;
    branch    = 1'b0;
    br_type   = 2'b00;
    done      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        src_b    = 2'b01;
        ir_write = bus.mem_ready_i;
        pc_write = bus.mem_ready_i;
        if (bus.mem_ready_i) begin
          state_d = S_DECODE;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = S_TRAP;
          fault_d = 2'b10;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DECODE: begin
        // PC + (imm<<2) precomputed for a possible branch
        src_b = 2'b11;
        case (bus.instr_op_i)
          OP_RTYPE:                                  state_d = (bus.funct_i == FN_JR) ? S_JUMP : S_EXEC;
          OP_ADDI, OP_ORI, OP_SLTIU, OP_LUI,
          OP_LW, OP_SW:                              state_d = S_EXEC;
          OP_BEQ, OP_BNE, OP_BLE, OP_BLTZ:           state_d = S_BRANCH;
          OP_J, OP_JAL:                              state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            fault_d = 2'b01;
          end
        endcase
      end

      S_EXEC: begin
        src_a = 1'b1;
        src_b = is_r ? 2'b00 : 2'b10;
        case (op_q)
          OP_RTYPE: alu_op = 3'b010;
          OP_LUI:   alu_op = 3'b101;
          OP_ORI:   alu_op = 3'b100;
          OP_SLTIU: alu_op = 3'b011;
          default:  alu_op = 3'b000;
        endcase
        if (op_q == OP_LW || is_sw) begin
          state_d = S_MEM;
        end else if (is_nop) begin
          state_d = S_FETCH;
          done    = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_read  = ~is_sw;
        mem_write = is_sw;
        if (bus.mem_ready_i) begin
          state_d = is_sw ? S_FETCH : S_WB;
          done    = is_sw;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = S_TRAP;
          fault_d = 2'b10;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = is_r ? 2'b01 : 2'b00;
        if (op_q == OP_LW)       wsrc = 2'b01;
        else if (op_q == OP_LUI) wsrc = 2'b10;
        done    = 1'b1;
        state_d = S_FETCH;
      end

      S_BRANCH: begin
        src_a  = 1'b1;
        alu_op = 3'b001;
        branch = 1'b1;
        pc_src = 2'b01;
        case (op_q)
          OP_BEQ:  br_type = 2'b10;
          OP_BNE:  br_type = 2'b11;
          OP_BLTZ: br_type = 2'b01;
          default: br_type = 2'b00;
        endcase
        done    = 1'b1;
        state_d = S_FETCH;
      end

      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = is_jr ? 2'b10 : 2'b11;
        if (op_q == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = 2'b10;
          wsrc      = 2'b11;
        end
        done    = 1'b1;
        state_d = S_FETCH;
      end

      default: ; // TRAP: everything quiet until reset
    endcase
  end

  assign bus.PC_write_o    = pc_write;
  assign bus.IR_write_o    = ir_write;
  assign bus.MemRead_o     = mem_read;
  assign bus.MemWrite_o    = mem_write;
  assign bus.RegWrite_o    = reg_write;
  assign bus.RegDst_o      = reg_dst;
  assign bus.RegWriteSrc_o = wsrc;
  assign bus.ALUSrcA_o     = src_a;
  assign bus.ALUSrcB_o     = src_b;
  assign bus.ALU_op_o      = alu_op;
  assign bus.PC_src_o      = pc_src;
  assign bus.Branch_o      = branch;
  assign bus.Branch_type_o = br_type;
  assign bus.instr_done_o  = done;
  assign bus.fault_o       = fault_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-cycle expected output records are queued by
// the stimulus side from an instruction-level model; a negedge monitor compares.
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if bus();

  mc_control_unit #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, mr, mw, rw;
    logic [1:0] rdst, rws;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic       br;
    logic [1:0] bt;
    logic       done;
    logic [1:0] flt;
  } rec_t;

  typedef enum int {C_R, C_NOP, C_IMM, C_LW, C_SW, C_BR, C_JMP, C_ILL} cls_t;

  rec_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:                      return (fn == 6'h00) ? C_NOP : (fn == 6'h08) ? C_JMP : C_R;
      6'h08, 6'h0d, 6'h0b, 6'h0f: return C_IMM;
      6'h23:                      return C_LW;
      6'h2b:                      return C_SW;
      6'h01, 6'h04, 6'h05, 6'h06: return C_BR;
      6'h02, 6'h03:               return C_JMP;
      default:                    return C_ILL;
    endcase
  endfunction

  function automatic rec_t blank(input logic [2:0] st);
    rec_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic rec_t r_fetch(input logic rdy);
    rec_t r = blank(3'd0);
    r.mr = 1'b1; r.sb = 2'b01; r.pcw = rdy; r.irw = rdy;
    return r;
  endfunction

  function automatic rec_t r_decode();
    rec_t r = blank(3'd1);
    r.sb = 2'b11;
    return r;
  endfunction

  function automatic rec_t r_exec(input cls_t c, input logic [5:0] op);
    rec_t r = blank(3'd2);
    r.sa = 1'b1;
    r.sb = (c == C_R || c == C_NOP) ? 2'b00 : 2'b10;
    case (op)
      6'h00:   r.alu = 3'b010;
      6'h0f:   r.alu = 3'b101;
      6'h0d:   r.alu = 3'b100;
      6'h0b:   r.alu = 3'b011;
      default: r.alu = 3'b000;   // lw, sw, addi
    endcase
    r.done = (c == C_NOP);
    return r;
  endfunction

  function automatic rec_t r_mem(input bit sw, input logic rdy);
    rec_t r = blank(3'd3);
    r.mr = !sw; r.mw = sw; r.done = sw && rdy;
    return r;
  endfunction

  function automatic rec_t r_wb(input cls_t c, input logic [5:0] op);
    rec_t r = blank(3'd4);
    r.rw = 1'b1;
    r.rdst = (c == C_R) ? 2'b01 : 2'b00;
    r.rws  = (op == 6'h23) ? 2'b01 : (op == 6'h0f) ? 2'b10 : 2'b00;
    r.done = 1'b1;
    return r;
  endfunction

  function automatic rec_t r_br(input logic [5:0] op);
    rec_t r = blank(3'd5);
    r.sa = 1'b1; r.alu = 3'b001; r.br = 1'b1; r.pcs = 2'b01; r.done = 1'b1;
    r.bt = (op == 6'h04) ? 2'b10 : (op == 6'h05) ? 2'b11 : (op == 6'h06) ? 2'b00 : 2'b01;
    return r;
  endfunction

  function automatic rec_t r_jmp(input logic [5:0] op);
    rec_t r = blank(3'd6);
    r.pcw = 1'b1; r.done = 1'b1;
    r.pcs = (op == 6'h00) ? 2'b10 : 2'b11;
    if (op == 6'h03) begin
      r.rw = 1'b1; r.rdst = 2'b10; r.rws = 2'b11;
    end
    return r;
  endfunction

  function automatic rec_t r_trap(input logic [1:0] f);
    rec_t r = blank(3'd7);
    r.flt = f;
    return r;
  endfunction

  // One clock: drive inputs just after the edge and queue what should show.
  task automatic step(input logic rdy, input logic r, input rec_t e, input string tag);
    @(posedge clk);
    #1;
    rst = r;
    bus.mem_ready_i = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Whole instruction; rst_at >= 0 asserts reset during that MEM wait cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input int rst_at);
    cls_t c = classify(op, fn);
    bus.instr_op_i = op;
    bus.funct_i    = fn;
    for (int i = 0; i < fw; i++) step(1'b0, 1'b0, r_fetch(1'b0), "fetch_wait");
    step(1'b1, 1'b0, r_fetch(1'b1), "fetch");
    step(rnd(), 1'b0, r_decode(), "decode");
    case (c)
      C_ILL: begin
        for (int i = 0; i < 10; i++) step(rnd(), 1'b0, r_trap(2'b01), "trap_illegal");
        step(1'b0, 1'b1, r_trap(2'b01), "trap_reset");
      end
      C_BR:  step(rnd(), 1'b0, r_br(op), "branch");
      C_JMP: step(rnd(), 1'b0, r_jmp(op), "jump");
      default: begin
        step(rnd(), 1'b0, r_exec(c, op), "exec");
        if (c == C_LW || c == C_SW) begin
          for (int i = 0; i < mw; i++) begin
            if (i == rst_at) begin
              step(1'b0, 1'b1, r_mem(c == C_SW, 1'b0), "mem_reset");
              return;
            end
            step(1'b0, 1'b0, r_mem(c == C_SW, 1'b0), "mem_wait");
          end
          step(1'b1, 1'b0, r_mem(c == C_SW, 1'b1), "mem");
          if (c == C_LW) step(rnd(), 1'b0, r_wb(c, op), "wb");
        end else if (c != C_NOP) begin
          step(rnd(), 1'b0, r_wb(c, op), "wb");
        end
      end
    endcase
  endtask

  // Monitor: compare whatever the DUT shows against the oldest expectation
  always @(negedge clk) begin
    rec_t g, e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g.st = bus.state_o;       g.pcw = bus.PC_write_o;   g.irw = bus.IR_write_o;
      g.mr = bus.MemRead_o;     g.mw = bus.MemWrite_o;    g.rw = bus.RegWrite_o;
      g.rdst = bus.RegDst_o;    g.rws = bus.RegWriteSrc_o; g.sa = bus.ALUSrcA_o;
      g.sb = bus.ALUSrcB_o;     g.alu = bus.ALU_op_o;     g.pcs = bus.PC_src_o;
      g.br = bus.Branch_o;      g.bt = bus.Branch_type_o; g.done = bus.instr_done_o;
      g.flt = bus.fault_o;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h (state got %0d exp %0d)", t, g, e, g.st, e.st);
      end
    end
  end

  logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h08, 6'h0d, 6'h0b, 6'h0f, 6'h23,
                           6'h2b, 6'h04, 6'h05, 6'h06, 6'h01, 6'h02, 6'h03};
  logic [5:0] fns [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h08};

  initial begin
    bus.instr_op_i  = '0;
    bus.funct_i     = '0;
    bus.mem_ready_i = 1'b0;
    // reset held two cycles; the second shows the reset state
    @(posedge clk); #1;
    step(1'b0, 1'b1, r_fetch(1'b0), "reset_state");

    run_instr(6'h00, 6'h20, 0, 0, -1);   // add
    run_instr(6'h23, 6'h00, 0, 3, -1);   // lw, 3 wait states
    run_instr(6'h04, 6'h00, 0, 0, -1);   // beq
    run_instr(6'h03, 6'h00, 0, 0, -1);   // jal
    run_instr(6'h3f, 6'h00, 0, 0, -1);   // illegal -> trap, then reset

    // fetch timeout: 15 waiting cycles, trap on the 16th
    bus.instr_op_i = 6'h00;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, r_fetch(1'b0), "timeout_wait");
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, r_trap(2'b10), "timeout_trap");
    step(1'b0, 1'b1, r_trap(2'b10), "timeout_reset");

    run_instr(6'h2b, 6'h00, 0, 3, 1);    // sw, reset mid-MEM
    run_instr(6'h2b, 6'h00, 1, 2, -1);   // sw completes
    run_instr(6'h00, 6'h00, 0, 0, -1);   // nop
    run_instr(6'h00, 6'h08, 0, 0, -1);   // jr

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 13)];
      fn = fns[$urandom_range(0, 6)];
      run_instr(op, fn, $urandom_range(0, 4), $urandom_range(0, 4), -1);
    end
    run_instr(6'h1c, 6'h00, 2, 0, -1);   // another illegal opcode
    run_instr(6'h23, 6'h00, 0, 14, -1);  // longest legal memory wait

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
